// File: rtl/bram_blocks_stream_reader.sv
// bram_blocks_stream_reader
//   Read-side initiator for the block BRAM wrapper. A start pulse issues
//   exactly NUM_BLOCKS single-cycle read strobes. Returned words pass
//   through a small credit-controlled first-word-fall-through FIFO, so the
//   Montgomery/modexp datapath can stall without losing in-flight reads.
//   Blocks leave as a ready/valid stream with a last flag.
//
// Ports
//   clk_in                     sole clock, rising edge
//   rst_n_in                   asynchronous active-low reset
//   start_in                   begin a pass (honoured only while idle)
//   read_next_block_valid_out  read strobe to BRAM, one block per high cycle
//   read_block_in              BRAM read data
//   read_block_valid_in        BRAM data valid, READ_LATENCY after strobe
//   block_out                  FIFO head (zero when empty)
//   block_valid_out            FIFO non-empty
//   block_ready_in             consumer accepts on valid & ready
//   block_last_out             head is block NUM_BLOCKS-1
//   busy_out                   pass in progress
//   done_out                   one-cycle pulse after last block accepted
//   overflow_error_out         sticky: data arrived while FIFO full
//   abort_in                   abandon pass (BRAM_READER_ABORT_EN only)
//
// Build option
//   BRAM_READER_ABORT_EN  adds abort_in and the FLUSH state.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start_in
// ISSUE  | issuing strobes while credit allows
// DRAIN  | all strobes issued, streaming remaining blocks
// FLUSH  | aborted: finish strobes, discard data, wait for responses

module bram_blocks_stream_reader #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  output logic                     read_next_block_valid_out,
  input  logic [REGISTER_SIZE-1:0] read_block_in,
  input  logic                     read_block_valid_in,
  output logic [REGISTER_SIZE-1:0] block_out,
  output logic                     block_valid_out,
  input  logic                     block_ready_in,
  output logic                     block_last_out,
  output logic                     busy_out,
  output logic                     done_out,
`ifdef BRAM_READER_ABORT_EN
  output logic                     overflow_error_out,
  input  logic                     abort_in
`else
  output logic                     overflow_error_out
`endif
);

  localparam int CNT_W  = $clog2(NUM_BLOCKS) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]  NUM_BLOCKS_C = CNT_W'(NUM_BLOCKS);
  localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(NUM_BLOCKS - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C      = FCNT_W'(FIFO_DEPTH);
  localparam logic [FCNT_W:0]   DEPTH_WIDE   = (FCNT_W + 1)'(FIFO_DEPTH);

  // The FIFO must cover the whole read pipeline plus the head word, and the
  // pointers rely on natural wrap.
  if (FIFO_DEPTH < READ_LATENCY + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least READ_LATENCY+2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
`ifdef BRAM_READER_ABORT_EN
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
`else
    S_DRAIN = 2'd2
`endif
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         req_cnt;
  logic [CNT_W-1:0]         pop_cnt;
  logic [FCNT_W-1:0]        out_cnt;
  logic [FCNT_W-1:0]        fifo_cnt;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [REGISTER_SIZE-1:0] mem [FIFO_DEPTH];

  logic             strobe;
  logic             flush_fifo;
  logic             done_nxt;
  logic             pop;
  logic             push;
  logic             accept_rsp;
  logic             fifo_full;
  logic             credit_ok;
  logic [FCNT_W:0]  credit_used;

  // Credit counts words already requested but not yet accepted downstream.
  assign credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign credit_ok   = credit_used < DEPTH_WIDE;
  assign fifo_full   = fifo_cnt == DEPTH_C;

  assign block_valid_out = fifo_cnt != '0;
  assign pop             = block_valid_out & block_ready_in;
  assign block_out       = block_valid_out ? mem[rd_ptr] : '0;
  assign block_last_out  = block_valid_out & (pop_cnt == LAST_IDX);

  assign read_next_block_valid_out = strobe;
  assign busy_out                  = state != S_IDLE;

  // Data is only kept while a pass is live; the abort edge also drops it.
  assign accept_rsp = read_block_valid_in & (state == S_ISSUE || state == S_DRAIN) & ~flush_fifo;
  assign push       = accept_rsp & (~fifo_full | pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= S_IDLE;
      done_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_out <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    strobe     = 1'b0;
    flush_fifo = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_in) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        strobe = credit_ok & (req_cnt < NUM_BLOCKS_C);
        if (strobe && req_cnt == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && block_last_out) state_nxt = S_IDLE;
      end
`ifdef BRAM_READER_ABORT_EN
      S_FLUSH: begin
        // Remaining strobes keep the BRAM address counter aligned for the
        // next pass; credit no longer matters since data is discarded.
        strobe = req_cnt < NUM_BLOCKS_C;
        if (req_cnt == NUM_BLOCKS_C && out_cnt == '0) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef BRAM_READER_ABORT_EN
    if (abort_in && (state == S_ISSUE || state == S_DRAIN)) begin
      state_nxt  = S_FLUSH;
      flush_fifo = 1'b1;
    end
`endif
    done_nxt = (state == S_DRAIN) && (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_cnt <= '0;
      out_cnt <= '0;
      pop_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (start_in) begin
        req_cnt <= '0;
        out_cnt <= '0;
        pop_cnt <= '0;
      end
    end else begin
      if (strobe) req_cnt <= req_cnt + CNT_W'(1);
      // A stray response with nothing outstanding must not wrap the count,
      // otherwise credit would never be granted again.
      if (strobe && !read_block_valid_in)
        out_cnt <= out_cnt + FCNT_W'(1);
      else if (!strobe && read_block_valid_in && out_cnt != '0)
        out_cnt <= out_cnt - FCNT_W'(1);
      if (pop) pop_cnt <= pop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_cnt           <= '0;
      overflow_error_out <= 1'b0;
    end else begin
      if (flush_fifo) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          fifo_cnt <= fifo_cnt + FCNT_W'(1);
        else if (pop && !push)
          fifo_cnt <= fifo_cnt - FCNT_W'(1);
      end
      if (accept_rsp && fifo_full && !pop) overflow_error_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= read_block_in;
  end

endmodule

// File: tb/tb_bram_blocks_stream_reader.sv
// Bench for bram_blocks_stream_reader: BRAM model returning the address,
// expected stream held as a queue of block indices per pass.
module tb_bram_blocks_stream_reader;

  localparam int RS = 32;
  localparam int NB = 128;
  localparam int RL = 2;
  localparam int FD = 4;

  logic          clk_in;
  logic          rst_n_in;
  logic          start_in;
  logic          read_next_block_valid_out;
  logic [RS-1:0] read_block_in;
  logic          read_block_valid_in;
  logic [RS-1:0] block_out;
  logic          block_valid_out;
  logic          block_ready_in;
  logic          block_last_out;
  logic          busy_out;
  logic          done_out;
  logic          overflow_error_out;
`ifdef BRAM_READER_ABORT_EN
  logic          abort_in;
`endif

  bram_blocks_stream_reader #(
    .REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in                    (clk_in),
    .rst_n_in                  (rst_n_in),
    .start_in                  (start_in),
    .read_next_block_valid_out (read_next_block_valid_out),
    .read_block_in             (read_block_in),
    .read_block_valid_in       (read_block_valid_in),
    .block_out                 (block_out),
    .block_valid_out           (block_valid_out),
    .block_ready_in            (block_ready_in),
    .block_last_out            (block_last_out),
    .busy_out                  (busy_out),
    .done_out                  (done_out),
`ifdef BRAM_READER_ABORT_EN
    .overflow_error_out        (overflow_error_out),
    .abort_in                  (abort_in)
`else
    .overflow_error_out        (overflow_error_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // BRAM model: returns its address READ_LATENCY cycles after each strobe.
  logic          inject;
  logic [RL-1:0] pv;
  logic [RS-1:0] pd [RL];
  logic [RS-1:0] bram_addr;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pv        <= '0;
      bram_addr <= '0;
      for (int i = 0; i < RL; i++) pd[i] <= '0;
    end else begin
      pv[0] <= read_next_block_valid_out;
      pd[0] <= bram_addr;
      for (int i = 1; i < RL; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (read_next_block_valid_out)
        bram_addr <= (bram_addr == RS'(NB - 1)) ? '0 : bram_addr + 1;
    end
  end

  assign read_block_valid_in = pv[RL-1] | inject;
  assign read_block_in       = inject ? 32'hDEAD_BEEF : pd[RL-1];

  // Per-pass observation record
  int   exp_q[$];
  int   strobes, pops, done_cnt;
  int   first_strobe_edge, first_blk_edge, last_blk_edge, done_edge;
  int   t0;
  int   mon_e;
  logic busy_at_done;
  bit   aborting;

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (read_next_block_valid_out) begin
        strobes++;
        if (strobes == 1) first_strobe_edge = cyc + 1;
      end
      if (block_valid_out && block_ready_in) begin
        pops++;
        if (pops == 1) first_blk_edge = cyc + 1;
        last_blk_edge = cyc + 1;
        if (exp_q.size() == 0) check("extra_block", 32'(pops), NB);
        else begin
          mon_e = exp_q.pop_front();
          check("block_data", block_out, 32'(mon_e));
          check("block_last", 32'(block_last_out), 32'(mon_e == NB - 1));
        end
      end
      if (busy_out && !aborting) check("credit", 32'((strobes - pops) <= FD), 1);
      if (done_out) begin
        done_cnt++;
        done_edge    = cyc + 1;
        busy_at_done = busy_out;
      end
    end
  end

  // Ready driver: 0 always, 1 random, 2 stall 20 from first valid,
  // 3 stall plus stray response, 4 ready until 30 blocks then low.
  int ready_mode;
  int hold_cnt;
  int stall_strobes;

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0: block_ready_in = 1'b1;
        1: block_ready_in = 1'($urandom_range(0, 1));
        2, 3: begin
          if (hold_cnt == 0 && !block_valid_out) block_ready_in = 1'b0;
          else if (hold_cnt < 20) begin
            block_ready_in = 1'b0;
            hold_cnt++;
            if (hold_cnt == 20) stall_strobes = strobes;
          end else block_ready_in = 1'b1;
          inject = (ready_mode == 3) && (hold_cnt == 10);
        end
        default: block_ready_in = (pops < 30);
      endcase
    end
  end

  task automatic start_pass(input int mode);
    #1;
    ready_mode    = mode;
    hold_cnt      = 0;
    stall_strobes = -1;
    strobes = 0; pops = 0; done_cnt = 0;
    first_strobe_edge = 0; first_blk_edge = 0; last_blk_edge = 0; done_edge = 0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(i);
    start_in = 1'b1;
    t0 = cyc + 1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input bit timing);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (done_out) begin got = 1; break; end
    end
    #1;
    check("done_seen", 32'(got), 1);
    check("strobes", 32'(strobes), NB);
    check("blocks", 32'(pops), NB);
    check("queue_left", 32'(exp_q.size()), 0);
    check("busy_at_done", 32'(busy_at_done), 0);
    if (timing) begin
      check("first_strobe_edge", 32'(first_strobe_edge - t0), 1);
      check("first_block_edge", 32'(first_blk_edge - t0), 2 + RL);
      check("last_block_edge", 32'(last_blk_edge - t0), 1 + RL + NB);
      check("done_edge", 32'(done_edge - t0), 2 + RL + NB);
      @(negedge clk_in);
      check("done_pulse", 32'(done_out), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, 32'(read_next_block_valid_out), 0);
    check({tag, "_valid"}, 32'(block_valid_out), 0);
    check({tag, "_data"}, block_out, 0);
    check({tag, "_last"}, 32'(block_last_out), 0);
    check({tag, "_busy"}, 32'(busy_out), 0);
    check({tag, "_done"}, 32'(done_out), 0);
    check({tag, "_ovf"}, 32'(overflow_error_out), 0);
  endtask

  initial begin
    bit got;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    block_ready_in = 1'b1;
    inject = 1'b0;
    ready_mode = 0;
    aborting = 1'b0;
`ifdef BRAM_READER_ABORT_EN
    abort_in = 1'b0;
`endif
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero("reset");
    rst_n_in = 1'b1;

    // Response while idle must not enter the FIFO.
    @(posedge clk_in); #1 inject = 1'b1;
    @(posedge clk_in); #1 inject = 1'b0;
    @(negedge clk_in);
    check("idle_push", 32'(block_valid_out), 0);

    start_pass(0); wait_done(1);

    start_pass(2); wait_done(0);
    check("stall_strobes", 32'(stall_strobes), FD);
    check("stall_ovf", 32'(overflow_error_out), 0);

    for (int p = 0; p < 3; p++) begin
      start_pass(1); wait_done(0);
      check("random_ovf", 32'(overflow_error_out), 0);
    end

    start_pass(3); wait_done(0);
    check("inject_stall_strobes", 32'(stall_strobes), FD);
    check("ovf_set", 32'(overflow_error_out), 1);

    // start_in during a pass is ignored
    start_pass(1);
    repeat (40) @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done(0);
    check("ovf_sticky", 32'(overflow_error_out), 1);

    // Asynchronous reset mid-pass
    start_pass(0);
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (pops >= 50) begin got = 1; break; end
    end
    check("reach_block_50", 32'(got), 1);
    #3 rst_n_in = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    start_pass(0); wait_done(1);

`ifdef BRAM_READER_ABORT_EN
    start_pass(4);
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (pops >= 30) begin got = 1; break; end
    end
    check("reach_block_30", 32'(got), 1);
    aborting = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b0;
    check("abort_valid", 32'(block_valid_out), 0);
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      if (!busy_out) begin got = 1; break; end
    end
    check("abort_idle", 32'(got), 1);
    check("abort_strobes", 32'(strobes), NB);
    check("abort_outstanding", 32'(pv), 0);
    repeat (3) @(negedge clk_in);
    check("abort_no_done", 32'(done_cnt), 0);
    aborting = 1'b0;
    start_pass(0); wait_done(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
